vga_tile_ctrl: RTL and testbench
================================

Name: vga_tile_ctrl

Overview:
Parametrised VGA timing generator and tile-mode frame reader. It supports configurable video timing, tile size, sync polarity and memory read latency, plus an optional 16-entry palette mode. It sits between the CPU-visible video RAM (byte-per-tile framebuffer read as 32-bit words) and the board VGA DAC pins. It replaces the fixed 640x480 / 16x16 / RGB222 controller.

Parameters:
VGA_BITS, 8, DAC bits per colour channel; must be >= 2.
H_ACTIVE, 640, visible pixels per line.
H_FP, 16, horizontal front porch in clocks.
H_SYNC, 96, horizontal sync width in clocks.
H_BP, 48, horizontal back porch in clocks.
V_ACTIVE, 480, visible lines.
V_FP, 10, vertical front porch in lines.
V_SYNC, 2, vertical sync width in lines.
V_BP, 33, vertical back porch in lines.
TILE_SHIFT, 4, log2 of tile edge in pixels; tile is 2^TILE_SHIFT square.
HS_POL, 0, HS active level (0 = active-low).
VS_POL, 0, VS active level.
MEM_LAT, 1, clocks from vaddr to matching vdata; range 1..4.
PAL_MODE, 0, 0 = direct RGB222 byte; 1 = palette lookup.

Ports:
clk  in  1  pixel clock
rst  in  1  synchronous reset, active-high
vdata  in  32  word containing the byte at vaddr, valid MEM_LAT clocks after vaddr
vaddr  out  32  tile byte address = row*COLS + col, with COLS = H_ACTIVE>>TILE_SHIFT
pal_we  in  1  palette write strobe; ignored when PAL_MODE=0
pal_idx  in  4  palette entry to write
pal_data  in  3*VGA_BITS  entry value {R,G,B}
VGA_R, VGA_G, VGA_B  out  VGA_BITS each  colour outputs
VGA_HS_O  out  1  horizontal sync
VGA_VS_O  out  1  vertical sync
vblank  out  1  high while the output line is >= V_ACTIVE
frame_start  out  1  one-clock pulse coincident with output pixel (0,0)

Behaviour:
- Counters: h runs 0..H_TOTAL-1, where H_TOTAL = sum of the H_* parameters. At wrap, h goes to 0 and v increments. v runs 0..V_TOTAL-1, then wraps to 0. Default frame is 800x525 clocks (no off-by-one). Counter widths are $clog2 of the totals.
- Addressing:
  - col = h>>TILE_SHIFT, row = v>>TILE_SHIFT, vaddr = row*COLS + col.
  - vaddr is combinational from the counters and zero-extended to 32 bits.
  - Outside the active area vaddr is don't-care but must stay in 0..COLS*ROWS-1 (clamp col/row to their maxima).
- Byte lane: lane = vaddr[1:0] delayed MEM_LAT clocks; lane 0 = vdata[31:24], lane 3 = vdata[7:0] (big-endian).
- Colour, PAL_MODE=0: R = {byte[5:4], zeros}, G = {byte[3:2], zeros}, B = {byte[1:0], zeros}. byte[7:6] is ignored.
- Colour, PAL_MODE=1: byte[3:0] indexes the palette through a registered lookup; byte[7:4] is ignored.
- Palette storage: 16 x 3*VGA_BITS registers, all cleared to 0 by rst. A write lands at the clock edge. If a lookup reads the same entry in that cycle, it returns the old value (read-before-write).
- Pipeline: all outputs are registered. Output latency from counter value to pins is L = MEM_LAT+1 (PAL_MODE=0) or MEM_LAT+2 (PAL_MODE=1). HS, VS, blank, vblank and frame_start are delayed by the same L so they stay pixel-aligned with colour.
- Sync: HS is active when h is in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1]. VS is active when v is in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC-1]. Pins drive the active level per HS_POL/VS_POL, inactive level otherwise.
- Blanking: colour outputs are 0 whenever the delayed (h,v) is outside the active area.
- Reset:
  - h = v = 0; all delay-line stages are forced to the blank state.
  - Colours 0, HS/VS at inactive level, vblank 0, frame_start 0.
  - Reset mid-frame takes effect at the next edge. The first frame_start occurs L clocks after rst deasserts.
- Illegal parameters (VGA_BITS<2, MEM_LAT outside 1..4) are flagged by an elaboration-time $error.

Test Plan:
1. Defaults, rst held 3 clocks then released -> VGA_R/G/B = 0, HS = VS = 1 during reset; frame_start first pulses at clock L = 2 after release.
2. Defaults, free run 2 frames -> HS low for exactly 96 clocks every 800; VS low for exactly 2 lines every 525; frame_start period 420000 clocks; vblank high for 45 lines per frame.
3. Addressing -> h=15, v=0 gives vaddr = 0; h=16 gives 1; v=16, h=0 gives 40; h=639, v=479 gives 1199. Memory model returning word 0x30_0C_03_3F at address 0 -> the first four tiles of line 0 show R=0xC0, G=0xC0, B=0xC0 and then the remaining combinations in lane order.
4. MEM_LAT=3 with a delaying memory model -> first visible pixel colour still coincides with the first clock of the HS-inactive active region, with no lane slip.
5. PAL_MODE=1 -> write entry 5 = {0x12, 0x34, 0x56} and feed byte 0x05 -> output is 0x12/0x34/0x56. A write to entry 5 in the same cycle as its lookup shows the old value for that pixel and the new value on the next tile.
6. Small timing (H 8/2/2/2, V 4/1/1/1, TILE_SHIFT=1, HS_POL=1) -> HS is high for h in 10..11, line period 14, frame period 98 clocks; assert rst mid-line and check that outputs blank on the next clock.

Source files
------------

// File: rtl/vga_tile_ctrl.sv
// Parametrised VGA timing generator with a tile-mode frame reader.
// It fetches one byte per tile from video RAM and drives the DAC pins as either direct RGB222 or through a 16-entry palette.
module vga_tile_ctrl #(
  parameter int VGA_BITS   = 8,
  parameter int H_ACTIVE   = 640,
  parameter int H_FP       = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BP       = 48,
  parameter int V_ACTIVE   = 480,
  parameter int V_FP       = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BP       = 33,
  parameter int TILE_SHIFT = 4,
  parameter int HS_POL     = 0,
  parameter int VS_POL     = 0,
  parameter int MEM_LAT    = 1,
  parameter int PAL_MODE   = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [31:0]             vdata,
  output logic [31:0]             vaddr,
  input  logic                    pal_we,
  input  logic [3:0]              pal_idx,
  input  logic [3*VGA_BITS-1:0]   pal_data,
  output logic [VGA_BITS-1:0]     VGA_R,
  output logic [VGA_BITS-1:0]     VGA_G,
  output logic [VGA_BITS-1:0]     VGA_B,
  output logic                    VGA_HS_O,
  output logic                    VGA_VS_O,
  output logic                    vblank,
  output logic                    frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);
  localparam int COLS    = H_ACTIVE >> TILE_SHIFT;
  localparam int ROWS    = V_ACTIVE >> TILE_SHIFT;
  localparam int L       = (PAL_MODE != 0) ? MEM_LAT + 2 : MEM_LAT + 1;
  localparam int CW      = 3 * VGA_BITS;
  localparam int unsigned MLAT = MEM_LAT;

  localparam logic [31:0] H_ACT32   = 32'(H_ACTIVE);
  localparam logic [31:0] V_ACT32   = 32'(V_ACTIVE);
  localparam logic [31:0] HS_START  = 32'(H_ACTIVE + H_FP);
  localparam logic [31:0] HS_END    = 32'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [31:0] VS_START  = 32'(V_ACTIVE + V_FP);
  localparam logic [31:0] VS_END    = 32'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [31:0] COLS32    = 32'(COLS);
  localparam logic [31:0] COL_MAX   = 32'(COLS - 1);
  localparam logic [31:0] ROW_MAX   = 32'(ROWS - 1);
  localparam logic [HW-1:0] H_LAST  = HW'(H_TOTAL - 1);
  localparam logic [VW-1:0] V_LAST  = VW'(V_TOTAL - 1);
  localparam logic        HS_ON     = (HS_POL != 0);
  localparam logic        VS_ON     = (VS_POL != 0);

  if (VGA_BITS < 2) begin : g_bad_vga_bits
    $error("vga_tile_ctrl: VGA_BITS must be >= 2");
  end
  if (MEM_LAT < 1 || MEM_LAT > 4) begin : g_bad_mem_lat
    $error("vga_tile_ctrl: MEM_LAT must be in 1..4");
  end

  logic [HW-1:0]   h_q, h_d;
  logic [VW-1:0]   v_q, v_d;
  logic [31:0]     h_ext, v_ext, col, row;
  logic            pix_active, hs_on, vs_on, vb_now, fs_now;

  logic [L-1:0]    act_q, act_d;
  logic [L-1:0]    hs_q, hs_d;
  logic [L-1:0]    vs_q, vs_d;
  logic [L-1:0]    vb_q, vb_d;
  logic [L-1:0]    fs_q, fs_d;
  logic [MEM_LAT-1:0][1:0] lane_q, lane_d;

  logic [7:0]      vbyte;
  logic [CW-1:0]   src_rgb;
  logic [CW-1:0]   rgb_q, rgb_d;

  always_comb begin
    h_d = h_q;
    v_d = v_q;
    if (h_q == H_LAST) begin
      h_d = '0;
      if (v_q == V_LAST) v_d = '0;
      else               v_d = v_q + VW'(1);
    end else begin
      h_d = h_q + HW'(1);
    end
  end

  // Clamping keeps vaddr inside the framebuffer during blanking, where the read is discarded.
  always_comb begin
    h_ext = 32'(h_q);
    v_ext = 32'(v_q);
    col   = h_ext >> TILE_SHIFT;
    row   = v_ext >> TILE_SHIFT;
    if (col > COL_MAX) col = COL_MAX;
    if (row > ROW_MAX) row = ROW_MAX;
    vaddr      = row * COLS32 + col;
    pix_active = (h_ext < H_ACT32) && (v_ext < V_ACT32);
    hs_on      = (h_ext >= HS_START) && (h_ext < HS_END);
    vs_on      = (v_ext >= VS_START) && (v_ext < VS_END);
    vb_now     = (v_ext >= V_ACT32);
    fs_now     = (h_q == '0) && (v_q == '0);
  end

  always_comb begin
    act_d = {act_q[L-2:0], pix_active};
    hs_d  = {hs_q[L-2:0], hs_on ? HS_ON : ~HS_ON};
    vs_d  = {vs_q[L-2:0], vs_on ? VS_ON : ~VS_ON};
    vb_d  = {vb_q[L-2:0], vb_now};
    fs_d  = {fs_q[L-2:0], fs_now};
    lane_d    = lane_q;
    lane_d[0] = vaddr[1:0];
    for (int unsigned k = 1; k < MLAT; k++) lane_d[k] = lane_q[k-1];
  end

  always_comb begin
    vbyte = '0;
    case (lane_q[MEM_LAT-1])
      2'd0:    vbyte = vdata[31:24];
      2'd1:    vbyte = vdata[23:16];
      2'd2:    vbyte = vdata[15:8];
      default: vbyte = vdata[7:0];
    endcase
  end

  if (PAL_MODE != 0) begin : g_pal
    logic [CW-1:0] pal_mem_q [16];
    logic [CW-1:0] pal_mem_d [16];
    logic [CW-1:0] pal_rd_q, pal_rd_d;

    // Lookup reads the registered array, so a same-edge write is seen one pixel later.
    always_comb begin
      pal_mem_d = pal_mem_q;
      if (pal_we) pal_mem_d[pal_idx] = pal_data;
      pal_rd_d = pal_mem_q[vbyte[3:0]];
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        for (int unsigned i = 0; i < 16; i++) pal_mem_q[i] <= '0;
        pal_rd_q <= '0;
      end else begin
        pal_mem_q <= pal_mem_d;
        pal_rd_q  <= pal_rd_d;
      end
    end

    assign src_rgb = pal_rd_q;
  end else begin : g_direct
    always_comb begin
      src_rgb = '0;
      src_rgb[3*VGA_BITS-1 -: 2] = vbyte[5:4];
      src_rgb[2*VGA_BITS-1 -: 2] = vbyte[3:2];
      src_rgb[VGA_BITS-1   -: 2] = vbyte[1:0];
    end
  end

  always_comb begin
    rgb_d = act_q[L-2] ? src_rgb : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      h_q    <= '0;
      v_q    <= '0;
      act_q  <= '0;
      hs_q   <= {L{~HS_ON}};
      vs_q   <= {L{~VS_ON}};
      vb_q   <= '0;
      fs_q   <= '0;
      lane_q <= '0;
      rgb_q  <= '0;
    end else begin
      h_q    <= h_d;
      v_q    <= v_d;
      act_q  <= act_d;
      hs_q   <= hs_d;
      vs_q   <= vs_d;
      vb_q   <= vb_d;
      fs_q   <= fs_d;
      lane_q <= lane_d;
      rgb_q  <= rgb_d;
    end
  end

  assign VGA_R       = rgb_q[3*VGA_BITS-1 -: VGA_BITS];
  assign VGA_G       = rgb_q[2*VGA_BITS-1 -: VGA_BITS];
  assign VGA_B       = rgb_q[VGA_BITS-1   -: VGA_BITS];
  assign VGA_HS_O    = hs_q[L-1];
  assign VGA_VS_O    = vs_q[L-1];
  assign vblank      = vb_q[L-1];
  assign frame_start = fs_q[L-1];

endmodule

// File: tb/tb_vga_tile_ctrl.sv
// Directed bench for vga_tile_ctrl: default 640x480 timing, a small MEM_LAT=3 timing, and a small palette-mode instance.
module tb_vga_tile_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_a, rst_s;
  logic        pal_we;
  logic [3:0]  pal_idx;
  logic [23:0] pal_data;

  logic [31:0] vaddr_a, vdata_a, vaddr_b, vdata_b, vaddr_c, vdata_c;
  logic [7:0]  r_a, g_a, b_a, r_b, g_b, b_b, r_c, g_c, b_c;
  logic        hs_a, vs_a, vb_a, fs_a;
  logic        hs_b, vs_b, vb_b, fs_b;
  logic        hs_c, vs_c, vb_c, fs_c;
  logic [23:0] rgb_a, rgb_b, rgb_c;

  assign rgb_a = {r_a, g_a, b_a};
  assign rgb_b = {r_b, g_b, b_b};
  assign rgb_c = {r_c, g_c, b_c};

  function automatic logic [31:0] mem_a(input logic [31:0] a);
    return (a[31:2] == 30'd0) ? 32'h300C033F : 32'h3F3F3F3F;
  endfunction

  function automatic logic [31:0] mem_b(input logic [31:0] a);
    if (a[31:2] == 30'd0) return 32'h300C033F;
    if (a[31:2] == 30'd1) return 32'h152A003F;
    return 32'h0;
  endfunction

  logic [31:0] a_pipe;
  logic [31:0] b_pipe [3];
  always @(posedge clk) begin
    a_pipe    <= vaddr_a;
    b_pipe[0] <= vaddr_b;
    b_pipe[1] <= b_pipe[0];
    b_pipe[2] <= b_pipe[1];
  end
  assign vdata_a = mem_a(a_pipe);
  assign vdata_b = mem_b(b_pipe[2]);
  assign vdata_c = 32'h05050505;

  vga_tile_ctrl dut_a (
    .clk(clk), .rst(rst_a), .vdata(vdata_a), .vaddr(vaddr_a),
    .pal_we(pal_we), .pal_idx(pal_idx), .pal_data(pal_data),
    .VGA_R(r_a), .VGA_G(g_a), .VGA_B(b_a),
    .VGA_HS_O(hs_a), .VGA_VS_O(vs_a), .vblank(vb_a), .frame_start(fs_a)
  );

  vga_tile_ctrl #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .TILE_SHIFT(1), .HS_POL(1), .MEM_LAT(3), .PAL_MODE(0)
  ) dut_b (
    .clk(clk), .rst(rst_s), .vdata(vdata_b), .vaddr(vaddr_b),
    .pal_we(pal_we), .pal_idx(pal_idx), .pal_data(pal_data),
    .VGA_R(r_b), .VGA_G(g_b), .VGA_B(b_b),
    .VGA_HS_O(hs_b), .VGA_VS_O(vs_b), .vblank(vb_b), .frame_start(fs_b)
  );

  vga_tile_ctrl #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .TILE_SHIFT(1), .HS_POL(1), .MEM_LAT(1), .PAL_MODE(1)
  ) dut_c (
    .clk(clk), .rst(rst_s), .vdata(vdata_c), .vaddr(vaddr_c),
    .pal_we(pal_we), .pal_idx(pal_idx), .pal_data(pal_data),
    .VGA_R(r_c), .VGA_G(g_c), .VGA_B(b_c),
    .VGA_HS_O(hs_c), .VGA_VS_O(vs_c), .vblank(vb_c), .frame_start(fs_c)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int pos      = 0;
  int lows     = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h (pos %0d)", tag, got, exp, pos);
    end
  endtask

  task automatic chk1(input string tag, input logic got, input logic exp);
    chk(tag, {31'd0, got}, {31'd0, exp});
  endtask

  task automatic chkc(input string tag, input logic [23:0] got, input logic [23:0] exp);
    chk(tag, {8'd0, got}, {8'd0, exp});
  endtask

  // Position counts negedges since the last reset release; the counter value equals pos.
  task automatic goto(input int n);
    while (pos < n) begin
      @(negedge clk);
      pos++;
    end
  endtask

  initial begin
    rst_a = 1'b1; rst_s = 1'b1;
    pal_we = 1'b0; pal_idx = 4'd0; pal_data = 24'h0;
    repeat (3) @(negedge clk);

    chkc("a_rst_rgb", rgb_a, 24'h0);
    chk1("a_rst_hs", hs_a, 1'b1);
    chk1("a_rst_vs", vs_a, 1'b1);
    chk1("a_rst_fs", fs_a, 1'b0);
    chk1("a_rst_vblank", vb_a, 1'b0);

    rst_a = 1'b0; pos = 0;
    goto(1);   chk1("a_fs_early", fs_a, 1'b0);
    goto(2);   chk1("a_fs_first", fs_a, 1'b1);
               chkc("a_tile0", rgb_a, 24'hC00000);
               chk1("a_hs_active_area", hs_a, 1'b1);
    goto(3);   chk1("a_fs_single", fs_a, 1'b0);
    goto(15);  chk("a_vaddr_h15", vaddr_a, 32'd0);
    goto(16);  chk("a_vaddr_h16", vaddr_a, 32'd1);
    goto(18);  chkc("a_tile1", rgb_a, 24'h00C000);
    goto(34);  chkc("a_tile2", rgb_a, 24'h0000C0);
    goto(50);  chkc("a_tile3", rgb_a, 24'hC0C0C0);
    goto(641); chkc("a_last_pixel", rgb_a, 24'hC0C0C0);
    goto(642); chkc("a_hblank", rgb_a, 24'h0);
    goto(657); chk1("a_hs_pre", hs_a, 1'b1);
    goto(658); chk1("a_hs_start", hs_a, 1'b0);
    goto(753); chk1("a_hs_end", hs_a, 1'b0);
    goto(754); chk1("a_hs_post", hs_a, 1'b1);
    goto(799); chk("a_vaddr_clamp", vaddr_a, 32'd39);
    goto(802);
    lows = 0;
    for (int i = 0; i < 800; i++) begin
      if (hs_a == 1'b0) lows++;
      goto(pos + 1);
    end
    chk("a_hs_low_count", 32'(lows), 32'd96);
    chk1("a_vs_idle", vs_a, 1'b1);
    goto(12800); chk("a_vaddr_row1", vaddr_a, 32'd40);
    goto(13439); chk("a_vaddr_row1_end", vaddr_a, 32'd79);

    rst_s = 1'b0; pos = 0;
    pal_we = 1'b1; pal_idx = 4'd5; pal_data = 24'h123456;
    goto(1);   pal_we = 1'b0;
    goto(3);   chk1("b_fs_early", fs_b, 1'b0);
               chkc("b_pre_rgb", rgb_b, 24'h0);
               chk1("c_fs_first", fs_c, 1'b1);
               chkc("c_pal_px0", rgb_c, 24'h123456);
    goto(4);   chk1("b_fs_first", fs_b, 1'b1);
               chkc("b_px0", rgb_b, 24'hC00000);
               chk1("b_hs_idle", hs_b, 1'b0);
               chkc("c_pal_px1", rgb_c, 24'h123456);
               pal_we = 1'b1; pal_data = 24'hABCDEF;
    goto(5);   pal_we = 1'b0;
               chkc("b_px1", rgb_b, 24'hC00000);
               chkc("c_pal_px2", rgb_c, 24'h123456);
    goto(6);   chkc("b_px2", rgb_b, 24'h00C000);
               chkc("c_pal_same_cycle_old", rgb_c, 24'h123456);
    goto(7);   chkc("c_pal_next_tile_new", rgb_c, 24'hABCDEF);
    goto(8);   chkc("b_px4", rgb_b, 24'h0000C0);
    goto(10);  chkc("b_px6", rgb_b, 24'hC0C0C0);
    goto(11);  chkc("c_hblank", rgb_c, 24'h0);
    goto(12);  chkc("b_hblank", rgb_b, 24'h0);
               chk("b_vaddr_col_clamp", vaddr_b, 32'd3);
    goto(13);  chk1("b_hs_h9", hs_b, 1'b0);
    goto(14);  chk1("b_hs_h10", hs_b, 1'b1);
    goto(15);  chk1("b_hs_h11", hs_b, 1'b1);
    goto(16);  chk1("b_hs_h12", hs_b, 1'b0);
    goto(27);  chk1("b_hs_l1_h9", hs_b, 1'b0);
    goto(28);  chk1("b_hs_l1_h10", hs_b, 1'b1);
    goto(32);  chkc("b_row1_tile4", rgb_b, 24'h404040);
    goto(38);  chkc("b_row1_tile7", rgb_b, 24'hC0C0C0);
    goto(59);  chk1("b_vblank_pre", vb_b, 1'b0);
    goto(60);  chk1("b_vblank", vb_b, 1'b1);
    goto(73);  chk1("b_vs_pre", vs_b, 1'b1);
    goto(74);  chk1("b_vs_active", vs_b, 1'b0);
    goto(82);  chk("b_vaddr_row_clamp", vaddr_b, 32'd7);
    goto(88);  chk1("b_vs_post", vs_b, 1'b1);
    goto(101); chk1("b_fs_gap", fs_b, 1'b0);
    goto(102); chk1("b_fs_period", fs_b, 1'b1);
    goto(106); chkc("b_pre_rst_rgb", rgb_b, 24'h0000C0);
               chkc("c_pre_rst_rgb", rgb_c, 24'hABCDEF);
               rst_s = 1'b1;
    goto(107); chkc("b_midrst_rgb", rgb_b, 24'h0);
               chkc("c_midrst_rgb", rgb_c, 24'h0);
               chk1("b_midrst_hs", hs_b, 1'b0);
               chk1("b_midrst_vs", vs_b, 1'b1);
               chk1("b_midrst_fs", fs_b, 1'b0);
               chk1("b_midrst_vblank", vb_b, 1'b0);

    rst_s = 1'b0; pos = 0;
    goto(3);   chk1("c_fs_after_rst", fs_c, 1'b1);
               chkc("c_pal_cleared", rgb_c, 24'h0);
               chk1("b_fs_after_rst_early", fs_b, 1'b0);
    goto(4);   chk1("b_fs_after_rst", fs_b, 1'b1);
               chkc("b_px0_after_rst", rgb_b, 24'hC00000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
